// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings, register bit positions and defaults for the UART 16550
package uart_pkg;
  typedef enum logic [1:0] {C_IDLE = 2'd0, C_LOAD = 2'd1, C_BUSY = 2'd2} tx_state_t;
  localparam int FIFO_EN = 0;
  localparam int TX_CLR = 2;
  localparam int IER_THRE = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;
  localparam int TX_FIFO_DEPTH = 16;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular DEPTH x 8 store with run-time capacity; clear overrides push and pop
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr,
  input  logic [AW:0]   i_cap,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata,
  output logic [AW:0]   o_level,
  output logic          o_drop
);
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_level;
  logic w_push, w_pop;
  assign w_pop = i_pop && !i_clr && r_level != '0;
  // a full store still accepts a write when a character leaves in the same cycle
  assign w_push = i_push && !i_clr && (r_level < i_cap || w_pop);
  assign o_drop = i_push && !i_clr && !w_push;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: THR/FIFO staging, serializer load handshake, LSR THRE/TEMT and THRE interrupt
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = TX_FIFO_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_wr,
  input  logic [7:0]    cpu_wdata,
  input  logic          fifo_en,
  input  logic          fifo_clr,
  input  logic          iir_rd,
  input  logic          thre_ie,
  input  logic          thr_empty_in,
  input  logic          tx_done_in,
  output logic          tx_write_thr,
  output logic [7:0]    tx_thr_data,
  output logic [AW:0]   tx_level,
  output logic          thre,
  output logic          temt,
  output logic          thre_irq,
  output logic          wr_drop
);
  tx_state_t r_state, w_state_nx;
  logic r_fifo_en, r_thre_prev, r_ie_prev, r_irq, r_drop, r_wr;
  logic [7:0] r_data, w_data_nx, w_rdata;
  logic [AW:0] w_level, w_cap;
  logic w_clr, w_issue, w_drop, w_set, w_irq_nx;
  // switching between FIFO and 16450 mode flushes storage just like FCR[2]
  assign w_clr = fifo_clr || (fifo_en != r_fifo_en);
  assign w_cap = fifo_en ? (AW+1)'(DEPTH) : (AW+1)'(1);
  assign w_issue = r_state == C_IDLE && w_level != '0 && thr_empty_in && !w_clr;
  uart_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cpu_wr),
    .i_pop   (w_issue),
    .i_clr   (w_clr),
    .i_cap   (w_cap),
    .i_wdata (cpu_wdata),
    .o_rdata (w_rdata),
    .o_level (w_level),
    .o_drop  (w_drop)
  );
  always_comb begin
    w_data_nx = w_issue ? w_rdata : r_data;
    w_state_nx = r_state == C_IDLE ? (w_issue ? C_LOAD : C_IDLE) :
                 r_state == C_LOAD ? C_BUSY : (tx_done_in ? C_IDLE : C_BUSY);
  end
  assign thre = w_level == '0;
  assign temt = thre && r_state == C_IDLE && thr_empty_in;
  // a CPU write outranks a new set; a new set outranks an IIR read
  assign w_set = thre_ie && thre && (!r_thre_prev || !r_ie_prev);
  assign w_irq_nx = (cpu_wr || !thre_ie) ? 1'b0 : w_set ? 1'b1 : iir_rd ? 1'b0 : r_irq;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= C_IDLE;
      r_wr <= 1'b0;
      r_data <= '0;
      r_fifo_en <= 1'b0;
      r_thre_prev <= 1'b1;
      r_ie_prev <= 1'b0;
      r_irq <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_wr <= w_issue;
      r_data <= w_data_nx;
      r_fifo_en <= fifo_en;
      r_thre_prev <= thre;
      r_ie_prev <= thre_ie;
      r_irq <= w_irq_nx;
      r_drop <= w_drop;
    end
  assign tx_write_thr = r_wr;
  assign tx_thr_data = r_data;
  assign tx_level = w_level;
  assign thre_irq = r_irq;
  assign wr_drop = r_drop;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: queue-based reference model of the transmit path with a serializer model
module tb_uart_tx_ctrl;
  logic clk, rst, cpu_wr, fifo_en, fifo_clr, iir_rd, thre_ie, thr_empty_in, tx_done_in;
  logic [7:0] cpu_wdata, tx_thr_data;
  logic [4:0] tx_level;
  logic tx_write_thr, thre, temt, thre_irq, wr_drop;
  int checks, errors, cyc, issues, drops, t_wr, t_done, ser_len, ser_cnt;
  bit pend_wr, pend_done, inflight, exp_drop, en_q, ser_rand, ser_busy;
  logic [7:0] q[$];

  uart_tx_ctrl dut (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .fifo_en(fifo_en),
    .fifo_clr(fifo_clr), .iir_rd(iir_rd), .thre_ie(thre_ie), .thr_empty_in(thr_empty_in),
    .tx_done_in(tx_done_in), .tx_write_thr(tx_write_thr), .tx_thr_data(tx_thr_data),
    .tx_level(tx_level), .thre(thre), .temt(temt), .thre_irq(thre_irq), .wr_drop(wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // serializer: latches on the load pulse, busy for a while, then pulses tx_done
  always @(negedge clk) begin
    tx_done_in = 1'b0;
    if (rst) begin
      ser_busy = 1'b0;
      thr_empty_in = 1'b1;
    end else if (tx_write_thr) begin
      ser_busy = 1'b1;
      thr_empty_in = 1'b0;
      ser_cnt = ser_rand ? int'($urandom_range(0, 6)) : ser_len;
    end else if (ser_busy) begin
      if (ser_cnt == 0) begin
        tx_done_in = 1'b1;
        ser_busy = 1'b0;
        thr_empty_in = 1'b1;
      end else ser_cnt--;
    end
  end

  // monitor: pops the scoreboard on every load pulse and checks status every cycle
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      pend_wr = 0;
      pend_done = 0;
      inflight = 0;
    end else begin
      logic [7:0] e;
      chk("spurious_issue", {31'd0, tx_write_thr && q.size() == 0}, 0);
      if (tx_write_thr) begin
        issues++;
        inflight = 1;
        chk("issue_while_ser_busy", {31'd0, thr_empty_in}, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("tx_data", {24'd0, tx_thr_data}, {24'd0, e});
        end
      end
      if (pend_wr && (tx_write_thr || cyc >= t_wr)) begin
        chk("wr_to_issue_latency", tx_write_thr ? cyc : 0, t_wr);
        pend_wr = 0;
      end
      if (pend_done && (tx_write_thr || cyc >= t_done)) begin
        chk("done_to_issue_latency", tx_write_thr ? cyc : 0, t_done);
        pend_done = 0;
      end
      if (tx_done_in) begin
        inflight = 0;
        if (q.size() > 0) begin
          pend_done = 1;
          t_done = cyc + 1;
        end
      end
      chk("tx_level", {27'd0, tx_level}, q.size());
      chk("thre", {31'd0, thre}, {31'd0, q.size() == 0});
      chk("temt", {31'd0, temt}, {31'd0, q.size() == 0 && !inflight});
      chk("wr_drop", {31'd0, wr_drop}, {31'd0, exp_drop});
      if (!thre_ie) chk("irq_disabled", {31'd0, thre_irq}, 0);
      if (wr_drop) drops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
    cpu_wr = 0;
    fifo_clr = 0;
    iir_rd = 0;
    exp_drop = 0;
  endtask

  task automatic drive(input bit w, input logic [7:0] d, input bit c, input bit en);
    cpu_wr = w;
    cpu_wdata = d;
    fifo_clr = c;
    fifo_en = en;
    if (c || en != en_q) begin
      q.delete();
      pend_wr = 0;
      pend_done = 0;
    end else if (w) begin
      if (q.size() < (en ? 16 : 1)) begin
        if (temt) begin
          pend_wr = 1;
          t_wr = cyc + 2;
        end
        q.push_back(d);
      end else exp_drop = 1;
    end
    en_q = en;
    step();
  endtask

  task automatic do_reset(input bit en);
    fifo_en = en;
    thre_ie = 0;
    rst = 1;
    repeat (2) step();
    rst = 0;
    repeat (2) step();
    en_q = en;
  endtask

  task automatic drain(input string nm, input int lim);
    int n = 0;
    while (!(temt && q.size() == 0) && n < lim) begin
      step();
      n++;
    end
    chk(nm, {31'd0, n < lim}, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int i0, d0;
    rst = 1; cpu_wr = 0; cpu_wdata = 0; fifo_en = 0; fifo_clr = 0; iir_rd = 0; thre_ie = 0;
    thr_empty_in = 1; tx_done_in = 0; ser_len = 3; ser_rand = 0; exp_drop = 0; en_q = 0;
    repeat (2) step();
    chk("rst_write_thr", {31'd0, tx_write_thr}, 0);
    chk("rst_data", {24'd0, tx_thr_data}, 0);
    chk("rst_level", {27'd0, tx_level}, 0);
    chk("rst_thre", {31'd0, thre}, 1);
    chk("rst_temt", {31'd0, temt}, 1);
    chk("rst_irq", {31'd0, thre_irq}, 0);
    chk("rst_drop", {31'd0, wr_drop}, 0);

    // three back-to-back characters
    do_reset(1);
    ser_len = 4;
    i0 = issues;
    drive(1, 8'h55, 0, 1);
    drive(1, 8'hA3, 0, 1);
    drive(1, 8'h0F, 0, 1);
    drain("drain_three", 200);
    chk("three_issues", issues - i0, 3);

    // overfill in FIFO mode while the serializer is busy
    do_reset(1);
    ser_len = 60;
    drive(1, 8'h11, 0, 1);
    repeat (3) step();
    d0 = drops;
    for (int k = 0; k < 17; k++) drive(1, 8'(k * 7 + 1), 0, 1);
    step();
    chk("fifo_full_level", {27'd0, tx_level}, 16);
    chk("fifo_one_drop", drops - d0, 1);
    ser_len = 2;
    drain("drain_full", 2000);

    // 16450 mode holds a single character
    do_reset(0);
    ser_len = 30;
    drive(1, 8'h21, 0, 0);
    repeat (3) step();
    d0 = drops;
    drive(1, 8'h22, 0, 0);
    drive(1, 8'h23, 0, 0);
    step();
    chk("thr_level", {27'd0, tx_level}, 1);
    chk("thr_one_drop", drops - d0, 1);
    drain("drain_thr", 300);

    // flush with a character in flight and a same-cycle write
    do_reset(1);
    ser_len = 30;
    drive(1, 8'h31, 0, 1);
    repeat (3) step();
    for (int k = 0; k < 5; k++) drive(1, 8'(8'h40 + k), 0, 1);
    d0 = drops;
    i0 = issues;
    drive(1, 8'h99, 1, 1);
    step();
    chk("clr_level", {27'd0, tx_level}, 0);
    drain("drain_clr", 100);
    chk("clr_no_drop", drops - d0, 0);
    chk("clr_no_issue", issues - i0, 0);
    chk("clr_temt", {31'd0, temt}, 1);

    // THRE interrupt
    do_reset(1);
    ser_len = 2;
    thre_ie = 1;
    step();
    chk("irq_ie_rise", {31'd0, thre_irq}, 1);
    iir_rd = 1;
    step();
    chk("irq_iir_clear", {31'd0, thre_irq}, 0);
    drive(1, 8'h41, 0, 1);
    step();
    chk("irq_load_pulse", {31'd0, tx_write_thr}, 1);
    chk("irq_before_set", {31'd0, thre_irq}, 0);
    step();
    chk("irq_thre_rise", {31'd0, thre_irq}, 1);
    thre_ie = 0;
    step();
    chk("irq_ie_off", {31'd0, thre_irq}, 0);
    thre_ie = 1;
    step();
    chk("irq_ie_reassert", {31'd0, thre_irq}, 1);
    thre_ie = 0;
    step();
    thre_ie = 1;
    drive(1, 8'h42, 0, 1);
    chk("irq_wr_beats_set", {31'd0, thre_irq}, 0);
    drain("drain_irq", 100);

    // asynchronous reset during C_LOAD
    do_reset(1);
    ser_len = 3;
    drive(1, 8'h61, 0, 1);
    drive(1, 8'h62, 0, 1);
    chk("pre_rst_load", {31'd0, tx_write_thr}, 1);
    rst = 1;
    #1;
    chk("arst_write_thr", {31'd0, tx_write_thr}, 0);
    chk("arst_level", {27'd0, tx_level}, 0);
    chk("arst_thre", {31'd0, thre}, 1);
    chk("arst_irq", {31'd0, thre_irq}, 0);
    step();

    // randomized traffic
    do_reset(1);
    ser_rand = 1;
    for (int k = 0; k < 800; k++) begin
      int r;
      bit en, w, c;
      r = $urandom_range(0, 99);
      en = (r < 2) ? !fifo_en : fifo_en;
      c = (r >= 2 && r < 5);
      w = (r >= 40) && (q.size() < (en ? 16 : 1) || !thr_empty_in);
      iir_rd = ($urandom_range(0, 9) == 0);
      drive(w, 8'($urandom), c, en);
    end
    drain("drain_random", 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side controller for the UART 16550. It holds CPU-written characters in a transmit FIFO, or a single holding register in non-FIFO mode. It hands characters one at a time to the serial transmitter through that block's write_thr / thr_empty / tx_done handshake. It also produces the LSR THRE/TEMT status bits and the THRE interrupt. It sits between the register-file decode and the tx serializer.

Parameters:
DEPTH, 16, FIFO capacity in FIFO mode; power of two, at least 2.
AW, $clog2(DEPTH), FIFO pointer width.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cpu_wr  in  1  single-cycle THR write strobe
cpu_wdata  in  8  THR write data
fifo_en  in  1  FCR[0]; 1 = FIFO mode (capacity DEPTH), 0 = 16450 mode (capacity 1)
fifo_clr  in  1  FCR[2] pulse; flush the transmit FIFO
iir_rd  in  1  IIR read strobe; clears a pending THRE interrupt
thre_ie  in  1  IER[1], THRE interrupt enable
thr_empty_in  in  1  from serializer; 1 when serializer is idle
tx_done_in  in  1  from serializer; 1-cycle pulse at end of stop bit
tx_write_thr  out  1  1-cycle load pulse to serializer
tx_thr_data  out  8  character to serializer; valid while tx_write_thr=1
tx_level  out  AW+1  current FIFO occupancy
thre  out  1  LSR[5]
temt  out  1  LSR[6]
thre_irq  out  1  THRE interrupt request
wr_drop  out  1  1-cycle pulse when a CPU write is discarded

Behaviour:
- Reset values: tx_write_thr=0, tx_thr_data=0, tx_level=0, pointers=0, FSM=C_IDLE, thre_irq=0, wr_drop=0. thre=1 and temt=1 (serializer is idle under the same rst).
- Capacity CAP = fifo_en ? DEPTH : 1. Storage is circular; pointers wrap modulo DEPTH. Non-FIFO mode uses slot rd_ptr only.
- Push: cpu_wr with level<CAP, or with a pop in the same cycle. Data is written at wr_ptr, wr_ptr+1, level+1.
- Drop: cpu_wr with level==CAP and no pop. Data discarded, state unchanged, wr_drop=1 next cycle.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Clear: fifo_clr=1, or any change of fifo_en (compared with a registered copy), zeroes pointers and level at the next edge.
  - Clear beats a same-cycle push (no drop pulse) and a same-cycle pop (no issue).
  - A character already handed to the serializer is never aborted.
- FSM, registered outputs:
  - C_IDLE: if level>0, thr_empty_in=1 and no clear, then at the edge: tx_write_thr<=1, tx_thr_data<=mem[rd_ptr], rd_ptr+1, level-1, go C_LOAD.
  - C_LOAD: tx_write_thr is high for exactly this cycle; serializer latches here. Next edge: tx_write_thr<=0, go C_BUSY.
  - C_BUSY: wait for tx_done_in=1, then go C_IDLE.
- Latency: cpu_wr sampled at edge N into an empty, idle controller gives tx_write_thr=1 in the cycle after edge N+1.
- Back-to-back characters: the next tx_write_thr comes 2 cycles after tx_done_in, provided level>0.
- Never assert tx_write_thr while thr_empty_in=0.
- thre = (level==0), combinational.
- temt = thre && FSM==C_IDLE && thr_empty_in, combinational.
- thre_irq (registered):
  - Set when thre_ie=1 and thre rises, using a registered previous thre.
  - Also set when thre_ie rises while thre=1.
  - Cleared by cpu_wr, iir_rd, or thre_ie=0.
  - Same-cycle priority: cpu_wr clear beats set; set beats iir_rd.
- Reset mid-operation returns every register to its reset value immediately. No pulse survives reset.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings C_IDLE/C_LOAD/C_BUSY.
  - FCR bit positions (FIFO_EN=0, TX_CLR=2), IER_THRE=1, LSR_THRE=5, LSR_TEMT=6.
  - Default TX_FIFO_DEPTH=16.
- One sub-module, uart_sync_fifo: DEPTH x 8 storage, pointers, level, push/pop/clr with clear priority, variable capacity input.
- FSM, issue logic, status and interrupt stay in uart_tx_ctrl.

Test Plan:
- fifo_en=1; write 0x55, 0xA3, 0x0F back-to-back with a serializer model → three tx_write_thr pulses in order with data 0x55, 0xA3, 0x0F, each 2 cycles after the previous tx_done_in. tx_level goes 3→0. thre rises after the third issue; temt rises only after the third tx_done_in.
- fifo_en=1; 17 writes while serializer is busy → tx_level=16, exactly one wr_drop pulse on the 17th write, 17th byte never transmitted.
- fifo_en=0; two writes while busy → second write dropped (wr_drop=1), tx_level stays 1.
- fifo_en=1 with 5 queued and one character in flight; pulse fifo_clr in the same cycle as cpu_wr → tx_level=0, no drop. The in-flight character completes, temt=1 after its tx_done_in, no further tx_write_thr.
- thre_ie=1; write 0x41, it drains → thre_irq=1 the cycle after thre rises. iir_rd clears it. Toggling thre_ie 0→1 while empty re-asserts it. A cpu_wr concurrent with the set condition leaves it 0.
- Assert rst while in C_LOAD → tx_write_thr=0, tx_level=0, thre=1, thre_irq=0 immediately, without waiting for a clock edge.
